// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: sequential front-end for a 32-bit combinational ALU.
//
// Accepts MIPS R-type requests (funct + operands) on a valid/ready port and
// decodes funct to the 3-bit ALU op (op[2]=invert b / +1, op[1:0]=and/or/add/slt).
// The operands and op are registered onto the ALU. After one settle cycle the
// result and flags are captured. The response is then returned on a valid/ready port.
// SLT is completed here because the ALU's slt mux input is tied to 0.
//
// Optional feature: define ALU_TRAP_EN to turn signed overflow on add/sub into
// an error response. It is disabled by default.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   req_valid/req_ready   request handshake; req_funct, req_a (rs), req_b (rt)
//   alu_a/alu_b/alu_op    registered ALU inputs
//   alu_result/alu_cout/alu_zero/alu_set/alu_overflow   ALU outputs
//   rsp_valid/rsp_ready   response handshake; rsp_result, rsp_zero, rsp_ovf, rsp_err
//   ops_done              count of completed responses (wraps)
module alu_issue_ctrl #(
  parameter int unsigned       WIDTH      = 32,
  parameter logic [WIDTH-1:0]  ERR_RESULT = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [5:0]       req_funct,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_cout,
  input  logic             alu_zero,
  input  logic             alu_set,
  input  logic             alu_overflow,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             rsp_ovf,
  output logic             rsp_err,
  output logic [15:0]      ops_done
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;
  typedef enum logic [2:0] {KAnd, KOr, KAdd, KAddu, KSub, KSubu, KSlt, KIll} kind_e;

  state_e           state_q, state_d;
  kind_e            kind_q, kind_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [2:0]       alu_op_q, alu_op_d;
  logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic             rsp_zero_q, rsp_zero_d;
  logic             rsp_ovf_q, rsp_ovf_d;
  logic             rsp_err_q, rsp_err_d;
  logic [15:0]      ops_done_q, ops_done_d;

  // Decode of the incoming funct.
  kind_e            dec_kind;
  logic [2:0]       dec_op;

  // EXEC-cycle result formation.
  logic             sub_ovf;
  logic             ex_ovf;
  logic [WIDTH-1:0] ex_result;
  logic             ex_trap;

  // Carry-out is not reported; zero is recomputed from the final result.
  logic unused_flags;
  assign unused_flags = alu_cout ^ alu_zero;

  always_comb begin
    dec_kind = KIll;
    dec_op   = 3'b000;
    unique case (req_funct)
      6'b100100: begin dec_kind = KAnd;  dec_op = 3'b000; end
      6'b100101: begin dec_kind = KOr;   dec_op = 3'b001; end
      6'b100000: begin dec_kind = KAdd;  dec_op = 3'b010; end
      6'b100001: begin dec_kind = KAddu; dec_op = 3'b010; end
      6'b100010: begin dec_kind = KSub;  dec_op = 3'b110; end
      6'b100011: begin dec_kind = KSubu; dec_op = 3'b110; end
      6'b101010: begin dec_kind = KSlt;  dec_op = 3'b110; end
      default:   begin dec_kind = KIll;  dec_op = 3'b000; end
    endcase
  end

  always_comb begin
    // The ALU overflow looks at raw b31, which is wrong for a - b. Recompute it
    // from the operands and the adder sign bit (alu_set).
    sub_ovf = (alu_a_q[WIDTH-1] ^ alu_b_q[WIDTH-1]) & (alu_a_q[WIDTH-1] ^ alu_set);
    ex_ovf  = 1'b0;
    case (kind_q)
      KAdd, KAddu:       ex_ovf = alu_overflow;
      KSub, KSubu, KSlt: ex_ovf = sub_ovf;
      default:           ex_ovf = 1'b0;
    endcase
    // Signed less-than is the difference's sign corrected for overflow.
    if (kind_q == KSlt) begin
      ex_result = {{(WIDTH-1){1'b0}}, alu_set ^ ex_ovf};
    end else begin
      ex_result = alu_result;
    end
`ifdef ALU_TRAP_EN
    ex_trap = ex_ovf & ((kind_q == KAdd) | (kind_q == KSub));
`else
    ex_trap = 1'b0;
`endif
  end

  always_comb begin
    state_d      = state_q;
    kind_d       = kind_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_op_d     = alu_op_q;
    rsp_result_d = rsp_result_q;
    rsp_zero_d   = rsp_zero_q;
    rsp_ovf_d    = rsp_ovf_q;
    rsp_err_d    = rsp_err_q;
    ops_done_d   = ops_done_q;
    req_ready    = 1'b0;
    rsp_valid    = 1'b0;

    unique case (state_q)
      StIdle: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (dec_kind == KIll) begin
            // Illegal funct bypasses the ALU and leaves its inputs untouched.
            rsp_result_d = ERR_RESULT;
            rsp_zero_d   = 1'b0;
            rsp_ovf_d    = 1'b0;
            rsp_err_d    = 1'b1;
            state_d      = StResp;
          end else begin
            alu_a_d  = req_a;
            alu_b_d  = req_b;
            alu_op_d = dec_op;
            kind_d   = dec_kind;
            state_d  = StExec;
          end
        end
      end
      StExec: begin
        rsp_ovf_d = ex_ovf;
        if (ex_trap) begin
          rsp_result_d = ERR_RESULT;
          rsp_zero_d   = 1'b0;
          rsp_err_d    = 1'b1;
        end else begin
          rsp_result_d = ex_result;
          rsp_zero_d   = (ex_result == '0);
          rsp_err_d    = 1'b0;
        end
        state_d = StResp;
      end
      StResp: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          ops_done_d = ops_done_q + 16'd1;
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      kind_q       <= KAnd;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= 3'b000;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_ovf_q    <= 1'b0;
      rsp_err_q    <= 1'b0;
      ops_done_q   <= 16'd0;
    end else begin
      state_q      <= state_d;
      kind_q       <= kind_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_op_q     <= alu_op_d;
      rsp_result_q <= rsp_result_d;
      rsp_zero_q   <= rsp_zero_d;
      rsp_ovf_q    <= rsp_ovf_d;
      rsp_err_q    <= rsp_err_d;
      ops_done_q   <= ops_done_d;
    end
  end

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_op     = alu_op_q;
  assign rsp_result = rsp_result_q;
  assign rsp_zero   = rsp_zero_q;
  assign rsp_ovf    = rsp_ovf_q;
  assign rsp_err    = rsp_err_q;
  assign ops_done   = ops_done_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural ALU attached.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready;
  logic [5:0]  req_funct;
  logic [31:0] req_a, req_b;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [2:0]  alu_op;
  logic        alu_cout, alu_zero, alu_set, alu_overflow;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_result;
  logic        rsp_zero, rsp_ovf, rsp_err;
  logic [15:0] ops_done;

  int checks   = 0;
  int failures = 0;
  logic [15:0] exp_done = 16'd0;

  always #5 clk = ~clk;

  alu_issue_ctrl dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_funct(req_funct),
    .req_a(req_a), .req_b(req_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_cout(alu_cout), .alu_zero(alu_zero),
    .alu_set(alu_set), .alu_overflow(alu_overflow),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_zero(rsp_zero), .rsp_ovf(rsp_ovf), .rsp_err(rsp_err),
    .ops_done(ops_done)
  );

  // Behavioural ALU: overflow uses raw b31, slt input tied to 0.
  logic [31:0] bb;
  logic [32:0] sum;
  always_comb begin
    bb           = alu_op[2] ? ~alu_b : alu_b;
    sum          = {1'b0, alu_a} + {1'b0, bb} + {32'd0, alu_op[2]};
    alu_cout     = sum[32];
    alu_zero     = (sum[31:0] == 32'd0);
    alu_set      = sum[31];
    alu_overflow = ~(alu_a[31] ^ alu_b[31]) & (alu_a[31] ^ sum[31]);
    case (alu_op[1:0])
      2'b00:   alu_result = alu_a & bb;
      2'b01:   alu_result = alu_a | bb;
      2'b10:   alu_result = sum[31:0];
      default: alu_result = 32'd0;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // One transaction: drive, check ALU inputs after accept, latency, fields,
  // hold under backpressure, then handshake and ops_done.
  task automatic run_op(input string tag, input logic [5:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [2:0] eop, input logic [31:0] ea,
                        input logic [31:0] er, input logic ez, input logic eo,
                        input logic ee, input int elat, input int hold);
    int lat;
    @(negedge clk);
    req_valid = 1'b1; req_funct = f; req_a = a; req_b = b;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check({tag, "_aluop"}, {29'd0, alu_op}, {29'd0, eop});
    check({tag, "_alua"}, alu_a, ea);
    lat = 1;
    while (!rsp_valid && lat < 8) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!rsp_valid) begin
      check({tag, "_timeout"}, 32'd0, 32'd1);
      return;
    end
    check({tag, "_lat"}, lat, elat);
    check({tag, "_result"}, rsp_result, er);
    check({tag, "_flags"}, {29'd0, rsp_zero, rsp_ovf, rsp_err}, {29'd0, ez, eo, ee});
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, "_hold"}, {rsp_result[31:2], rsp_valid, req_ready},
            {er[31:2], 1'b1, 1'b0});
    end
    if (hold > 0) check({tag, "_done_held"}, {16'd0, ops_done}, {16'd0, exp_done});
    @(negedge clk); rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    exp_done = exp_done + 16'd1;
    check({tag, "_done"}, {16'd0, ops_done}, {16'd0, exp_done});
    check({tag, "_idle"}, {30'd0, rsp_valid, req_ready}, 32'd1);
  endtask

  logic trap;
  initial begin
`ifdef ALU_TRAP_EN
    trap = 1'b1;
`else
    trap = 1'b0;
`endif
    reset = 1'b1; req_valid = 1'b0; req_funct = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready_valid", {30'd0, req_ready, rsp_valid}, 32'd2);
    check("rst_alu", {alu_a[28:0], alu_op}, 32'd0);
    check("rst_rsp", {rsp_result[28:0], rsp_zero, rsp_ovf, rsp_err}, 32'd0);
    check("rst_done", {16'd0, ops_done}, 32'd0);
    @(negedge clk); reset = 1'b0;

    // Reset during EXEC aborts the op.
    @(negedge clk);
    req_valid = 1'b1; req_funct = 6'b100000; req_a = 32'd3; req_b = 32'd4;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("exec_busy", {31'd0, req_ready}, 32'd0);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    check("abort_state", {30'd0, req_ready, rsp_valid}, 32'd2);
    check("abort_done", {16'd0, ops_done}, 32'd0);
    @(negedge clk); reset = 1'b0;

    //      tag       funct       a             b             op      alu_a        result       z  o  e  lat hold
    run_op("add",    6'b100000, 32'd7,        32'd5,        3'b010, 32'd7,        32'd12,      0, 0, 0, 2, 0);
    run_op("slt_lt", 6'b101010, 32'hFFFFFFFF, 32'd1,        3'b110, 32'hFFFFFFFF, 32'd1,       0, 0, 0, 2, 0);
    run_op("slt_ov", 6'b101010, 32'h7FFFFFFF, 32'hFFFFFFFF, 3'b110, 32'h7FFFFFFF, 32'd0,       1, 1, 0, 2, 0);
    run_op("slt_eq", 6'b101010, 32'd5,        32'd5,        3'b110, 32'd5,        32'd0,       1, 0, 0, 2, 0);
    run_op("sub_ov", 6'b100010, 32'h80000000, 32'd1,        3'b110, 32'h80000000,
           trap ? 32'd0 : 32'h7FFFFFFF, 0, 1, trap, 2, 0);
    run_op("subu",   6'b100011, 32'h80000000, 32'd1,        3'b110, 32'h80000000, 32'h7FFFFFFF, 0, 1, 0, 2, 0);
    // Illegal funct leaves alu_* at the previous subu values.
    run_op("illegal", 6'b000000, 32'd9,       32'd9,        3'b110, 32'h80000000, 32'd0,       0, 0, 1, 1, 0);
    run_op("and_bp", 6'b100100, 32'hF0F0F0F0, 32'hFF00FF00, 3'b000, 32'hF0F0F0F0, 32'hF000F000, 0, 0, 0, 2, 5);
    run_op("or",     6'b100101, 32'h0000000F, 32'h000000F0, 3'b001, 32'h0000000F, 32'h000000FF, 0, 0, 0, 2, 0);
    run_op("addu_w", 6'b100001, 32'hFFFFFFFF, 32'd1,        3'b010, 32'hFFFFFFFF, 32'd0,       1, 0, 0, 2, 0);
    run_op("add_ov", 6'b100000, 32'h7FFFFFFF, 32'd1,        3'b010, 32'h7FFFFFFF,
           trap ? 32'd0 : 32'h80000000, 0, 1, trap, 2, 0);

    // Counter wrap: preload the count register, then complete one op.
    @(negedge clk);
    dut.ops_done_q = 16'hFFFF;
    exp_done = 16'hFFFF;
    run_op("wrap",   6'b100000, 32'd1,        32'd1,        3'b010, 32'd1,        32'd2,       0, 0, 0, 2, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
